// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and width helpers for the data-memory port arbiter.
// Widths here describe the default build; instances derive their own from parameters.
package data_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Never returns 0 so a degenerate parameter still yields a legal vector.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned NUM_REQ_DEF = 2;
    localparam int unsigned TIMEOUT_DEF = 255;
    localparam int unsigned OWNER_W     = clog2_min1(NUM_REQ_DEF);
    localparam int unsigned CNT_W       = clog2_min1(TIMEOUT_DEF + 1);

endpackage

// File: rtl/data_mem_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or above the pointer, else wrap to the lowest.
// Zero latency, no state; one-hot grant plus its index.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               vld_o
);

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!vld_o && req_i[i] && (IDX_W'(i) >= ptr_i)) begin
                vld_o    = 1'b1;
                gnt_o[i] = 1'b1;
                idx_o    = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!vld_o && req_i[i] && (IDX_W'(i) < ptr_i)) begin
                vld_o    = 1'b1;
                gnt_o[i] = 1'b1;
                idx_o    = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one data-memory port among NUM_REQ requesters, one outstanding transaction, with a watchdog.
// Memory-side fields are captured at arbitration and held until the memory grants; responses route back combinationally.
module data_mem_arbiter
    import data_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = NUM_REQ_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_REQ-1:0]    req_i,
    input  logic [NUM_REQ-1:0]    we_i,
    input  logic [NUM_REQ*4-1:0]  be_i,
    input  logic [NUM_REQ*32-1:0] addr_i,
    input  logic [NUM_REQ*32-1:0] wdata_i,
    output logic [NUM_REQ-1:0]    gnt_o,
    output logic [NUM_REQ-1:0]    rvalid_o,
    output logic [31:0]           rdata_o,
    output logic                  err_o,
    output logic                  data_req_o,
    input  logic                  data_gnt_i,
    output logic                  data_we_o,
    output logic [3:0]            data_be_o,
    output logic [31:0]           data_addr_o,
    output logic [31:0]           data_wdata_o,
    input  logic                  data_rvalid_i,
    input  logic [31:0]           data_rdata_i,
    input  logic                  data_err_i
);

    localparam int unsigned   IW       = clog2_min1(NUM_REQ);
    localparam int unsigned   CW       = clog2_min1(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);
    localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES);
    localparam bit            TO_EN    = (TIMEOUT_CYCLES != 0);

    state_e         state_q, state_d;
    logic [IW-1:0]  ptr_q, ptr_d;
    logic [IW-1:0]  owner_q, owner_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           data_req_q, data_req_d;
    logic           we_q, we_d;
    logic [3:0]     be_q, be_d;
    logic [31:0]    addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;

    logic [NUM_REQ-1:0] win_oh;
    logic [IW-1:0]      win_idx;
    logic               win_vld;
    logic               sel_we;
    logic [3:0]         sel_be;
    logic [31:0]        sel_addr;
    logic [31:0]        sel_wdata;
    logic               expire;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IW)
    ) u_rr (
        .req_i (req_i),
        .ptr_i (ptr_q),
        .gnt_o (win_oh),
        .idx_o (win_idx),
        .vld_o (win_vld)
    );

    // AND-OR mux of the winner's fields using the one-hot grant.
    always_comb begin
        sel_we    = 1'b0;
        sel_be    = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_oh[i]) begin
                sel_we    = sel_we    | we_i[i];
                sel_be    = sel_be    | be_i[i*4 +: 4];
                sel_addr  = sel_addr  | addr_i[i*32 +: 32];
                sel_wdata = sel_wdata | wdata_i[i*32 +: 32];
            end
        end
    end

    assign expire = TO_EN && (cnt_q == TO_LIMIT);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        data_req_d = data_req_q;
        we_d       = we_q;
        be_d       = be_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        gnt_o      = '0;
        rvalid_o   = '0;
        rdata_o    = '0;
        err_o      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    we_d       = sel_we;
                    be_d       = sel_be;
                    addr_d     = sel_addr;
                    wdata_d    = sel_wdata;
                    owner_d    = win_idx;
                    ptr_d      = (win_idx == LAST_IDX) ? '0 : win_idx + IW'(1);
                    cnt_d      = '0;
                    data_req_d = 1'b1;
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                cnt_d = cnt_q + CW'(1);
                // A grant on the expiry cycle takes priority over the watchdog.
                if (data_gnt_i) begin
                    gnt_o[owner_q] = 1'b1;
                    data_req_d     = 1'b0;
                    state_d        = ST_RESP;
                end else if (expire) begin
                    gnt_o[owner_q]    = 1'b1;
                    rvalid_o[owner_q] = 1'b1;
                    err_o             = 1'b1;
                    data_req_d        = 1'b0;
                    state_d           = ST_IDLE;
                end
            end
            ST_RESP: begin
                cnt_d = cnt_q + CW'(1);
                if (data_rvalid_i) begin
                    rvalid_o[owner_q] = 1'b1;
                    rdata_o           = data_rdata_i;
                    err_o             = data_err_i;
                    state_d           = ST_IDLE;
                end else if (expire) begin
                    rvalid_o[owner_q] = 1'b1;
                    err_o             = 1'b1;
                    state_d           = ST_IDLE;
                end
            end
            default: begin
                data_req_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            cnt_q      <= '0;
            data_req_q <= 1'b0;
            we_q       <= 1'b0;
            be_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            data_req_q <= data_req_d;
            we_q       <= we_d;
            be_q       <= be_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign data_req_o   = data_req_q;
    assign data_we_o    = we_q;
    assign data_be_o    = be_q;
    assign data_addr_o  = addr_q;
    assign data_wdata_o = wdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter (NUM_REQ=2, TIMEOUT_CYCLES=4): vector table plus hand sequences,
// with responses checked against a scoreboard queue filled when each request is driven.
module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [1:0]  req_i, we_i, gnt_o, rvalid_o;
    logic [7:0]  be_i;
    logic [63:0] addr_i, wdata_i;
    logic [31:0] rdata_o, data_addr_o, data_wdata_o, data_rdata_i;
    logic        err_o, data_req_o, data_gnt_i, data_we_o, data_rvalid_i, data_err_i;
    logic [3:0]  data_be_o;

    always #5 clk = ~clk;

    data_mem_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(4)) dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .be_i(be_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
        .rdata_o(rdata_o), .err_o(err_o), .data_req_o(data_req_o), .data_gnt_i(data_gnt_i),
        .data_we_o(data_we_o), .data_be_o(data_be_o), .data_addr_o(data_addr_o),
        .data_wdata_o(data_wdata_o), .data_rvalid_i(data_rvalid_i),
        .data_rdata_i(data_rdata_i), .data_err_i(data_err_i)
    );

    typedef struct {
        logic [1:0]  req;
        logic        we0;
        logic [31:0] addr0;
        logic [31:0] wdata0;
        int          gdly;
        int          rdly;
        logic [31:0] rdata;
        logic        err;
        logic [1:0]  exp_oh;
    } vec_t;

    typedef struct {
        logic [1:0]  rv;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t tbl[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] req, input logic we0, input logic [31:0] addr0,
                                input logic [31:0] wdata0, input int gdly, input int rdly,
                                input logic [31:0] rdata, input logic err, input logic [1:0] exp_oh);
        vec_t v;
        v.req = req; v.we0 = we0; v.addr0 = addr0; v.wdata0 = wdata0; v.gdly = gdly;
        v.rdly = rdly; v.rdata = rdata; v.err = err; v.exp_oh = exp_oh;
        return v;
    endfunction

    // Port 1 fields are derived from port 0 so the owner is visible on every memory-side field.
    task automatic drive_ports(input vec_t v);
        req_i   = v.req;
        we_i    = {~v.we0, v.we0};
        be_i    = {4'h3, 4'hF};
        addr_i  = {v.addr0 ^ 32'h8000_0000, v.addr0};
        wdata_i = {~v.wdata0, v.wdata0};
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "/data_req"}, data_req_o, 0);
        chk({tag, "/data_we"}, data_we_o, 0);
        chk({tag, "/data_be"}, data_be_o, 0);
        chk({tag, "/data_addr"}, data_addr_o, 0);
        chk({tag, "/data_wdata"}, data_wdata_o, 0);
        chk({tag, "/gnt"}, gnt_o, 0);
        chk({tag, "/rvalid"}, rvalid_o, 0);
        chk({tag, "/rdata"}, rdata_o, 0);
        chk({tag, "/err"}, err_o, 0);
    endtask

    // Entered just after a rising edge with the DUT idle; leaves just after the edge ending the response.
    task automatic run_vec(input vec_t v, input string tag);
        exp_t        e;
        logic        ew;
        logic [3:0]  eb;
        logic [31:0] ea, ed;
        drive_ports(v);
        e.rv = v.exp_oh; e.rdata = v.rdata; e.err = v.err;
        sbq.push_back(e);
        if (v.exp_oh[0]) begin
            ew = v.we0;  eb = 4'hF; ea = v.addr0;                 ed = v.wdata0;
        end else begin
            ew = ~v.we0; eb = 4'h3; ea = v.addr0 ^ 32'h8000_0000; ed = ~v.wdata0;
        end
        @(posedge clk); #1;
        for (int k = 0; k <= v.gdly; k++) begin
            data_gnt_i = (k == v.gdly);
            @(negedge clk);
            chk({tag, "/data_req_hi"}, data_req_o, 1);
            chk({tag, "/data_addr"}, data_addr_o, ea);
            chk({tag, "/gnt"}, gnt_o, (k == v.gdly) ? v.exp_oh : 2'b00);
            if (k == v.gdly) begin
                chk({tag, "/data_wdata"}, data_wdata_o, ed);
                chk({tag, "/data_we"}, data_we_o, ew);
                chk({tag, "/data_be"}, data_be_o, eb);
                chk({tag, "/rvalid_at_gnt"}, rvalid_o, 0);
            end
            @(posedge clk); #1;
        end
        data_gnt_i = 1'b0;
        for (int r = 0; r <= v.rdly; r++) begin
            data_rvalid_i = (r == v.rdly);
            data_rdata_i  = (r == v.rdly) ? v.rdata : 32'hCAFE_0000;
            data_err_i    = (r == v.rdly) ? v.err : 1'b0;
            @(negedge clk);
            chk({tag, "/data_req_lo"}, data_req_o, 0);
            chk({tag, "/rvalid"}, rvalid_o, (r == v.rdly) ? v.exp_oh : 2'b00);
            @(posedge clk); #1;
        end
        data_rvalid_i = 1'b0;
        data_rdata_i  = '0;
        data_err_i    = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rvalid_o != 2'b00) begin
            if (sbq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: rvalid_o=%b with nothing expected", rvalid_o);
            end else begin
                mon_e = sbq.pop_front();
                chk("sb_rvalid", rvalid_o, mon_e.rv);
                chk("sb_rdata", rdata_o, mon_e.rdata);
                chk("sb_err", err_o, mon_e.err);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench time limit");
    end

    initial begin
        tbl[0] = mk(2'b01, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 0, 0, 32'h0,         1'b0, 2'b01);
        tbl[1] = mk(2'b10, 1'b1, 32'h0000_2000, 32'h0000_0000, 0, 1, 32'hA5A5_0001, 1'b0, 2'b10);
        tbl[2] = mk(2'b11, 1'b0, 32'h0000_3000, 32'h1357_9BDF, 1, 0, 32'h1111_2222, 1'b0, 2'b01);
        tbl[3] = mk(2'b11, 1'b0, 32'h0000_3000, 32'h1357_9BDF, 0, 0, 32'h3333_4444, 1'b1, 2'b10);
        tbl[4] = mk(2'b11, 1'b1, 32'h0000_3004, 32'h2468_ACE0, 2, 1, 32'h0000_5555, 1'b0, 2'b01);
        tbl[5] = mk(2'b11, 1'b1, 32'h0000_3004, 32'h2468_ACE0, 0, 2, 32'h0000_7777, 1'b0, 2'b10);
        // Rvalid lands on the expiry cycle: the real response must win.
        tbl[6] = mk(2'b01, 1'b0, 32'h0000_4000, 32'h0000_0000, 3, 0, 32'h1234_5678, 1'b0, 2'b01);
        // Grant lands on the expiry cycle: a normal grant, no error.
        tbl[7] = mk(2'b10, 1'b0, 32'h0000_6000, 32'h0F0F_0F0F, 4, 0, 32'h9999_0000, 1'b0, 2'b10);

        rst_i = 1'b1; req_i = '0; we_i = '0; be_i = '0; addr_i = '0; wdata_i = '0;
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = '0; data_err_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1;
        rst_i = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Timeout in RESP, then a stray late response in IDLE.
        drive_ports(mk(2'b01, 1'b0, 32'h0000_5000, 32'h0, 0, 0, 32'h0, 1'b0, 2'b01));
        @(posedge clk); #1;
        data_gnt_i = 1'b1;
        @(negedge clk);
        chk("to_resp/gnt", gnt_o, 2'b01);
        @(posedge clk); #1;
        data_gnt_i = 1'b0; req_i = '0; data_rdata_i = 32'hFFFF_FFFF;
        sbq.push_back('{rv: 2'b01, rdata: 32'h0, err: 1'b1});
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk($sformatf("to_resp/rvalid_k%0d", k), rvalid_o, (k == 4) ? 2'b01 : 2'b00);
            @(posedge clk); #1;
        end
        data_rvalid_i = 1'b1; data_rdata_i = 32'h0000_BAD0;
        @(negedge clk);
        chk("stray_rvalid/rvalid", rvalid_o, 0);
        chk("stray_rvalid/rdata", rdata_o, 0);
        chk("stray_rvalid/data_req", data_req_o, 0);
        @(posedge clk); #1;
        data_rvalid_i = 1'b0; data_rdata_i = '0;

        // Timeout in REQ with a stray rvalid while waiting, then a stray grant in IDLE.
        drive_ports(mk(2'b10, 1'b0, 32'h0000_7000, 32'h0, 0, 0, 32'h0, 1'b0, 2'b10));
        sbq.push_back('{rv: 2'b10, rdata: 32'h0, err: 1'b1});
        @(posedge clk); #1;
        for (int k = 0; k <= 4; k++) begin
            data_rvalid_i = (k == 1);
            @(negedge clk);
            chk($sformatf("to_req/gnt_k%0d", k), gnt_o, (k == 4) ? 2'b10 : 2'b00);
            chk($sformatf("to_req/rvalid_k%0d", k), rvalid_o, (k == 4) ? 2'b10 : 2'b00);
            @(posedge clk); #1;
        end
        data_rvalid_i = 1'b0; req_i = '0; data_gnt_i = 1'b1;
        @(negedge clk);
        chk("stray_gnt/gnt", gnt_o, 0);
        chk("stray_gnt/data_req", data_req_o, 0);
        @(posedge clk); #1;
        data_gnt_i = 1'b0;

        // Reset while in RESP; pointer must return to 0.
        drive_ports(mk(2'b01, 1'b1, 32'h0000_8000, 32'h5555_AAAA, 0, 0, 32'h0, 1'b0, 2'b01));
        @(posedge clk); #1;
        data_gnt_i = 1'b1;
        @(posedge clk); #1;
        data_gnt_i = 1'b0; req_i = '0;
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);
        check_zero("mid_reset");
        run_vec(mk(2'b11, 1'b0, 32'h0000_9000, 32'h0000_0001, 0, 0, 32'h0BAD_F00D, 1'b0, 2'b01), "post_rst_ptr");
        run_vec(mk(2'b10, 1'b0, 32'h0000_A000, 32'h0000_0002, 1, 1, 32'h600D_600D, 1'b0, 2'b10), "post_rst_req10");
        req_i = '0;

        repeat (3) @(posedge clk);
        chk("sb_drained", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
